// File: rtl/button_bounce_gen.sv
// Bouncy raw button generator: each accepted level command becomes a burst of
// LFSR-spaced toggles, a settle interval and a one-cycle completion pulse.
module button_bounce_gen #(
  parameter int unsigned BOUNCE_PAIRS  = 2,
  parameter int unsigned MIN_GAP       = 3,
  parameter logic [7:0]  GAP_MASK      = 8'h07,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic CLK,
  input  logic i_Reset,
  input  logic i_Cmd_Valid,
  input  logic i_Cmd_Level,
  output logic o_Cmd_Ready,
  output logic o_Button_Raw,
  output logic o_Busy,
  output logic o_Done
);

  localparam int unsigned TOGGLES = 2 * BOUNCE_PAIRS + 1;
  localparam int unsigned TW      = $clog2(TOGGLES + 1);
  localparam int unsigned SW      = $clog2(SETTLE_CYCLES + 2);

  localparam logic [TW-1:0] TOGGLE_LAST = TW'(TOGGLES - 1);
  localparam logic [TW-1:0] TOGGLE_MAX  = TW'(TOGGLES);
  localparam logic [SW-1:0] SETTLE_END  = SW'(SETTLE_CYCLES);
  localparam logic [8:0]    MIN_GAP_W   = 9'(MIN_GAP);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          raw_q, raw_d;
  logic          level_q, level_d;
  logic [TW-1:0] tgl_q, tgl_d;
  logic [8:0]    wait_q, wait_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          ready_q, busy_q, done_q;
  logic [8:0]    gap_d;

  // Fibonacci LFSR step for x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Next-state logic: toggle scheduling, settle timing and LFSR advance
  always_comb begin
    state_d  = state_q;
    raw_d    = raw_q;
    level_d  = level_q;
    tgl_d    = tgl_q;
    wait_d   = wait_q;
    settle_d = settle_q;
    lfsr_d   = lfsr_next(lfsr_q);
    gap_d    = MIN_GAP_W + {1'b0, lfsr_q & GAP_MASK};

    case (state_q)
      ST_IDLE: begin
        if (i_Cmd_Valid) begin
          level_d  = i_Cmd_Level;
          tgl_d    = {TW{1'b0}};
          wait_d   = 9'd0;
          settle_d = {SW{1'b0}};
          if (i_Cmd_Level != raw_q) begin
            state_d = ST_BOUNCE;
          end else begin
            // the extra settle count makes the settle end land one edge later
            state_d = ST_SETTLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BOUNCE: begin
        if (wait_q == 9'd0) begin
          wait_d = gap_d - 9'd1;
          if (tgl_q != TOGGLE_MAX) begin
            tgl_d = tgl_q + TW'(1);
          end else begin
            tgl_d = tgl_q;
          end
          if (tgl_q == TOGGLE_LAST) begin
            raw_d    = level_q;
            state_d  = ST_SETTLE;
            settle_d = SW'(1);
          end else begin
            raw_d   = ~raw_q;
            state_d = ST_BOUNCE;
          end
        end else begin
          wait_d = wait_q - 9'd1;
        end
      end

      ST_SETTLE: begin
        if (settle_q == SETTLE_END) begin
          state_d = ST_DONE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state
  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= LFSR_SEED;
      raw_q    <= 1'b0;
      level_q  <= 1'b0;
      tgl_q    <= {TW{1'b0}};
      wait_q   <= 9'd0;
      settle_q <= {SW{1'b0}};
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      raw_q    <= raw_d;
      level_q  <= level_d;
      tgl_q    <= tgl_d;
      wait_q   <= wait_d;
      settle_q <= settle_d;
      ready_q  <= (state_d == ST_IDLE);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign o_Cmd_Ready  = ready_q;
  assign o_Button_Raw = raw_q;
  assign o_Busy       = busy_q;
  assign o_Done       = done_q;

endmodule
